// File: rtl/fifo_pkg.sv
// Shared types and constants for the threshold FIFO.
// Read-mode enum, default flag levels, count-width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_REGD = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int FIFO_AFULL_DEF  = 6;
  localparam int FIFO_AEMPTY_DEF = 1;

  // Count must hold 0..DEPTH, i.e. one bit more than the address.
  function automatic int cnt_width(input int aw);
    return $clog2((1 << aw) + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Two-port storage: synchronous write, asynchronous read.
// Ports: clk, w_en/w_addr/w_data write side, r_addr -> r_data read.
module fifo_mem #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with FWFT/registered read, count, level flags,
// flush and sticky overflow/underflow. Single clock, async reset_n.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 1,
  parameter int AFULL_LVL  = FIFO_AFULL_DEF,
  parameter int AEMPTY_LVL = FIFO_AEMPTY_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam fifo_mode_e MODE =
    (FWFT != 0) ? FIFO_FWFT : FIFO_REGD;

  typedef logic [CW-1:0] cnt_t;

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("ADDR_WIDTH must be >= 1");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_af
    $error("AFULL_LVL out of range 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_ae
    $error("AEMPTY_LVL out of range 0..DEPTH-1");
  end
  if (CW != ADDR_WIDTH + 1) begin : g_bad_cw
    $error("count width mismatch");
  end

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  cnt_t                  cnt_q;
  cnt_t                  cnt_nxt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_q;
  logic                  udf_q;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Flush wins: nothing is accepted alongside clr.
  assign wr_ok = ~clr & wr & (~full | rd);
  assign rd_ok = ~clr & rd & ~empty;

  assign full         = (cnt_q == cnt_t'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= cnt_t'(AFULL_LVL));
  assign almost_empty = (cnt_q <= cnt_t'(AEMPTY_LVL));
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  always_comb begin
    cnt_nxt = cnt_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt_q + cnt_t'(1);
      2'b01:   cnt_nxt = cnt_q - cnt_t'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      cnt_q <= cnt_nxt;
      if (wr & ~wr_ok) ovf_q <= 1'b1;
      if (rd & ~rd_ok) udf_q <= 1'b1;
    end
  end

  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .w_en   (wr_ok),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (mem_rd)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign r_data = empty ? '0 : mem_rd;
  end else begin : g_regd
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_q <= '0;
      else if (clr)   r_q <= '0;
      else if (rd_ok) r_q <= mem_rd;
    end

    assign r_data = r_q;
  end

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed scoreboard bench for fifo_thresh.
// Covers FWFT and registered instances.
module tb_fifo_thresh;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr, wr, rd;
  logic [7:0] w_data, r_data;
  logic       full, empty, afull, aempty, ovf, udf;
  logic [3:0] count;

  logic       clr_r, wr_r, rd_r;
  logic [7:0] w_data_r, r_data_r;
  logic       full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
  logic [3:0] count_r;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       movf, mudf;

  always #5 clk = ~clk;

  fifo_thresh #(.FWFT(1)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .wr(wr), .rd(rd), .w_data(w_data),
    .r_data(r_data), .full(full), .empty(empty),
    .almost_full(afull), .almost_empty(aempty),
    .count(count), .overflow(ovf), .underflow(udf)
  );

  fifo_thresh #(.FWFT(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .clr(clr_r),
    .wr(wr_r), .rd(rd_r), .w_data(w_data_r),
    .r_data(r_data_r), .full(full_r), .empty(empty_r),
    .almost_full(afull_r), .almost_empty(aempty_r),
    .count(count_r), .overflow(ovf_r), .underflow(udf_r)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(afull), 32'(n >= 6));
    chk({tag, ".aempty"}, 32'(aempty), 32'(n <= 1));
    chk({tag, ".ovf"}, 32'(ovf), 32'(movf));
    chk({tag, ".udf"}, 32'(udf), 32'(mudf));
    if (n == 0) chk({tag, ".rdata0"}, 32'(r_data), 32'h0);
    else chk({tag, ".rdata"}, 32'(r_data), 32'(q[0]));
  endtask

  // Drive one cycle from a negedge, update the model, check at next negedge.
  task automatic step(input string tag, input logic c,
                      input logic w, input logic r,
                      input logic [7:0] d);
    int  n;
    bit  wok, rok;
    logic [7:0] got;
    clr = c; wr = w; rd = r; w_data = d;
    n = q.size();
    @(posedge clk);
    if (c) begin
      q.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      rok = r && (n > 0);
      wok = w && ((n < DEPTH) || r);
      if (rok) got = q.pop_front();
      if (wok) q.push_back(d);
      if (w && !wok) movf = 1'b1;
      if (r && !rok) mudf = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    check_status(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 0; wr = 0; rd = 0; w_data = '0;
    clr_r = 0; wr_r = 0; rd_r = 0; w_data_r = '0;
    movf = 0; mudf = 0;
    repeat (2) @(negedge clk);
    check_status("reset");
    chk("reset.rdata_r", 32'(r_data_r), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 8; i++)
      step("fill", 0, 1, 0, 8'(i));
    step("ovf", 0, 1, 0, 8'hFF);

    for (int i = 0; i < 8; i++)
      step("drain", 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++)
      step("wrapw", 0, 1, 0, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++)
      step("wrapr", 0, 0, 1, 8'h00);

    for (int i = 0; i < 8; i++)
      step("refill", 0, 1, 0, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++)
      step("fullrw", 0, 1, 1, 8'h20 + 8'(i));
    for (int i = 0; i < 8; i++)
      step("drain2", 0, 0, 1, 8'h00);

    step("emptyrw", 0, 1, 1, 8'h77);
    step("emptyrw.rd", 0, 0, 1, 8'h00);

    step("fwft", 0, 1, 0, 8'h5A);
    step("fwft.rd", 0, 0, 1, 8'h00);

    for (int i = 0; i < 5; i++)
      step("pre_clr", 0, 1, 0, 8'h40 + 8'(i));
    step("clr", 1, 1, 1, 8'hEE);
    step("post_clr.w", 0, 1, 0, 8'h33);
    step("post_clr.r", 0, 0, 1, 8'h00);

    for (int i = 0; i < 3; i++)
      step("pre_rst", 0, 1, 0, 8'h60 + 8'(i));
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    movf = 0; mudf = 0;
    check_status("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst.w", 0, 1, 0, 8'h99);
    step("post_rst.w2", 0, 1, 0, 8'h9A);
    step("post_rst.r", 0, 0, 1, 8'h00);
    step("post_rst.r2", 0, 0, 1, 8'h00);

    wr_r = 1; w_data_r = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    wr_r = 0;
    chk("regd.pre_rd", 32'(r_data_r), 32'h0);
    chk("regd.count1", 32'(count_r), 32'd1);
    rd_r = 1;
    @(posedge clk);
    @(negedge clk);
    rd_r = 0;
    chk("regd.data", 32'(r_data_r), 32'h5A);
    chk("regd.empty", 32'(empty_r), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("regd.hold", 32'(r_data_r), 32'h5A);
    end
    rd_r = 1;
    @(posedge clk);
    @(negedge clk);
    rd_r = 0;
    chk("regd.rej_hold", 32'(r_data_r), 32'h5A);
    chk("regd.udf", 32'(udf_r), 32'd1);
    clr_r = 1;
    @(posedge clk);
    @(negedge clk);
    clr_r = 0;
    chk("regd.clr_data", 32'(r_data_r), 32'h0);
    chk("regd.clr_udf", 32'(udf_r), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_thresh.md
Name: fifo_thresh

Overview:
Parametrised synchronous FIFO, the next generation of the team's basic register-file FIFO. It adds the following:
- Selectable read mode: first-word-fall-through or registered.
- Occupancy count output.
- Programmable almost-full and almost-empty flags.
- Synchronous flush.
- Sticky overflow and underflow error flags.

It sits between producer and consumer stages in the datapath, with one clock for both sides.

Parameters:
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH entries (8 by default).
- DATA_WIDTH, 8, word width in bits.
- FWFT, 1, read mode. 1 = head word shown combinationally on r_data. 0 = r_data registered, updates the cycle after an accepted read.
- AFULL_LVL, 6, almost_full asserts when count >= AFULL_LVL. Legal range 1..DEPTH.
- AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush; pointers, count and sticky flags return to reset values
- wr  in  1  write request
- rd  in  1  read request
- w_data  in  DATA_WIDTH  write data
- r_data  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-transfer):
  - Pointers and count go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Registered-mode r_data goes to 0.
  - Storage array is not reset.
- Accept rules (evaluated on the state before the edge):
  - wr_ok = wr & (~full | rd).
  - rd_ok = rd & ~empty.
- Update at each rising edge:
  - wr_ok writes w_data at w_ptr; w_ptr advances by 1, wrapping at DEPTH.
  - rd_ok advances r_ptr by 1, wrapping at DEPTH.
  - count += wr_ok - rd_ok.
- Full with wr=1 and rd=1: both accepted, count stays at DEPTH.
- Empty with wr=1 and rd=1: write accepted, read rejected, underflow set, count becomes 1.
- wr=1 while full with rd=0: write dropped, storage untouched, overflow set.
- rd=1 while empty: no pointer change, underflow set.
- Sticky flags: stay set until clr or reset.
- clr:
  - Takes priority over wr and rd in the same cycle; neither is accepted and no flag is set.
  - Next cycle: count=0, empty=1, flags clear.
- Status flags: full, empty, almost_full, almost_empty are combinational decodes of the registered count. They take effect the same cycle count changes, with no extra latency.
- Read data, FWFT=1:
  - r_data = mem[r_ptr] while ~empty, and 0 while empty.
  - A word written into an empty FIFO appears on r_data the cycle after the write edge.
- Read data, FWFT=0:
  - On rd_ok, r_data <= mem[r_ptr], so one cycle of read latency.
  - r_data holds its value otherwise, including on rejected reads.
  - clr sets r_data to 0.
- Pointer width is ADDR_WIDTH; natural binary wrap is used, with no separate wrap bit. full and empty derive from count only.
- Elaboration-time assertions: AFULL_LVL and AEMPTY_LVL within their legal ranges, and ADDR_WIDTH >= 1.

Decomposition:
- Package fifo_pkg holds:
  - Typedef fifo_mode_e {FIFO_REGD=0, FIFO_FWFT=1}.
  - Function clog2-based helper for the count width (ADDR_WIDTH+1).
  - Default level constants FIFO_AFULL_DEF=6 and FIFO_AEMPTY_DEF=1.
- One sub-module, fifo_mem:
  - Parametrised two-port array with synchronous write (w_en, w_addr, w_data) and asynchronous read (r_addr -> r_data).
  - The top holds pointers, count, flags and the read-mode mux.

Test Plan (defaults: DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=1):
- Reset then fill: release reset_n and write 0x01..0x08 on consecutive cycles.
  - almost_empty drops after the 2nd write and almost_full rises after the 6th.
  - full=1 with count=8 after the 8th write.
  - A 9th write of 0xFF leaves count=8, sets overflow=1, and a later drain never returns 0xFF.
- Drain with wrap: after the fill, read 8 times, then write 0xA0..0xA3 and read them back.
  - Data returns in order 0x01..0x08 then 0xA0..0xA3, exercising pointer wrap.
  - empty=1 and count=0 at the end.
- Simultaneous access:
  - Full with wr=rd=1 for 4 cycles: count stays 8 and the oldest 4 words come out in order.
  - Empty with wr=rd=1: count=1, underflow=1, and the written word is readable next.
- Read modes:
  - FWFT=1: write 0x5A into the empty FIFO; r_data=0x5A the next cycle with no rd.
  - FWFT=0: same write then rd=1; r_data=0x5A one cycle after the rd edge, and it holds through 3 idle cycles.
- Flush priority: count=5 and clr=1 with wr=rd=1 in the same cycle.
  - Next cycle: count=0, empty=1, overflow=underflow=0.
  - The following write of 0x33 reads back as 0x33.
- Async reset mid-operation: assert reset_n=0 between clock edges while count=3.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the FIFO operates normally from empty.
